// File: rtl/point_mult_arbiter.sv
// Round-robin arbiter sharing one scalar-multiplication engine between NUM_REQ key requesters,
// sequencing the engine Reset/Done protocol and returning tagged results with a watchdog timeout.
module point_mult_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic                           clk,
    input  logic                           Reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*256-1:0]         req_key,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]     resp_id,
    output logic [255:0]                   resp_x,
    output logic [255:0]                   resp_y,
    output logic                           resp_err,
    output logic                           busy,
    output logic                           eng_reset,
    output logic [255:0]                   eng_key,
    input  logic                           eng_done,
    input  logic [255:0]                   eng_x,
    input  logic [255:0]                   eng_y
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned CW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StStart, StBusy, StResp} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_id;
    logic [255:0]     r_key;
    logic [255:0]     r_x;
    logic [255:0]     r_y;
    logic             r_err;
    logic [CW-1:0]    r_cnt;

    logic             w_any;
    logic [IDW-1:0]   w_gnt_idx;
    logic [NUM_REQ-1:0] w_gnt_onehot;
    logic             w_timeout;

    // First requesting index at or above the rr pointer, wrapping around.
    always_comb begin
        int unsigned cand;
        w_any     = 1'b0;
        w_gnt_idx = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_any && req_valid[IDW'(cand)]) begin
                w_any     = 1'b1;
                w_gnt_idx = IDW'(cand);
            end
        end
    end

    always_comb begin
        w_gnt_onehot            = '0;
        w_gnt_onehot[w_gnt_idx] = 1'b1;
    end

    assign w_timeout = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Gated by Reset_n so no requester sees an acceptance that is not latched.
    assign req_ready  = (r_state == StIdle && w_any && Reset_n) ? w_gnt_onehot : '0;
    assign resp_valid = (r_state == StResp);
    assign busy       = (r_state != StIdle);
    assign eng_reset  = (r_state != StBusy);
    assign eng_key    = r_key;
    assign resp_id    = r_id;
    assign resp_x     = r_x;
    assign resp_y     = r_y;
    assign resp_err   = r_err;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_any) w_state_next = StStart;
            StStart: w_state_next = StBusy;
            StBusy:  if (eng_done || w_timeout) w_state_next = StResp;
            StResp:  if (resp_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rr_ptr <= '0;
            r_id     <= '0;
            r_key    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_key    <= req_key[{w_gnt_idx, 8'h00} +: 256];
                        r_id     <= w_gnt_idx;
                        r_rr_ptr <= IDW'((32'(w_gnt_idx) + 1) % NUM_REQ);
                    end
                end
                StStart: r_cnt <= '0;
                StBusy: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Done wins over a timeout landing in the same cycle.
                    if (eng_done) begin
                        r_x   <= eng_x;
                        r_y   <= eng_y;
                        r_err <= (eng_x == '0) && (eng_y == '0);
                    end else if (w_timeout) begin
                        r_x   <= '0;
                        r_y   <= '0;
                        r_err <= 1'b1;
                    end
                end
                StResp: ;
                default: ;
            endcase
        end
    end

endmodule
